// File: rtl/vga_timing_monitor.sv
// Passive VGA raster sink: rebuilds pixel coordinates, measures line/frame geometry, flags errors and lock.
// Optional per-frame pixel checksum is built when VGA_MON_SUM_EN is defined.
module vga_timing_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  iPIX,
    input  logic        iERR_CLR,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oPIX_VALID,
    output logic [10:0] oH_TOTAL,
    output logic [9:0]  oV_TOTAL,
    output logic [7:0]  oFRAME_CNT,
    output logic [15:0] oFRAME_SUM,
    output logic [3:0]  oERR,
    output logic        oLOCKED
);

    localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [9:0]  V_TOT_L = 10'(V_TOTAL);
    localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);

    typedef enum logic [1:0] {UNLOCKED, GOOD1, LOCKED} lock_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    lock_t       state_q, state_d;
    logic        hs_dly_q, vs_dly_q, blank_dly_q;
    logic        seen_hs_q, seen_vs_q, frame_bad_q, frame_bad_d;
    logic [10:0] h_cnt_q, h_cnt_d, a_cnt_q, a_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d, al_cnt_q, al_cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d, x_cur, y_cur;
    logic [3:0]  set_err, err_d;
    logic        hs_fall, vs_fall, blank_fall, h_chk, v_chk, act_line, mismatch;

    assign hs_fall    = hs_dly_q & ~iHS;
    assign vs_fall    = vs_dly_q & ~iVS;
    assign blank_fall = blank_dly_q & ~iBLANK_n;

    // Nothing is judged until one full line/frame has been bracketed by edges.
    assign h_chk    = hs_fall & seen_hs_q;
    assign v_chk    = vs_fall & seen_vs_q;
    assign act_line = h_chk & (a_cnt_q != '0);

    assign set_err[0] = h_chk & (h_cnt_q != H_TOT_L);
    assign set_err[1] = act_line & (a_cnt_q != H_ACT_L);
    assign set_err[2] = v_chk & (v_cnt_q != V_TOT_L);
    assign set_err[3] = v_chk & (al_cnt_q != V_ACT_L);
    assign mismatch   = |set_err;

    always_comb begin
        h_cnt_d  = hs_fall ? 11'd1 : sat_inc11(h_cnt_q);
        a_cnt_d  = hs_fall ? 11'd0 : (iBLANK_n ? sat_inc11(a_cnt_q) : a_cnt_q);
        // An HS fall on the VS-fall cycle opens the first line of the new frame.
        v_cnt_d  = vs_fall ? {9'd0, hs_fall} : (hs_fall ? sat_inc10(v_cnt_q) : v_cnt_q);
        al_cnt_d = vs_fall ? {9'd0, act_line} : (act_line ? sat_inc10(al_cnt_q) : al_cnt_q);
        x_cur    = hs_fall ? 10'd0 : x_q;
        x_d      = iBLANK_n ? sat_inc10(x_cur) : x_cur;
        y_cur    = vs_fall ? 10'd0 : y_q;
        y_d      = blank_fall ? sat_inc10(y_cur) : y_cur;
        err_d    = (oERR & ~{4{iERR_CLR}}) | set_err;
        frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | mismatch);
    end

    always_comb begin
        state_d = state_q;
        if (mismatch) begin
            state_d = UNLOCKED;
        end else if (v_chk && !frame_bad_q) begin
            case (state_q)
                UNLOCKED: state_d = GOOD1;
                GOOD1:    state_d = LOCKED;
                default:  state_d = LOCKED;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= UNLOCKED;
            hs_dly_q    <= 1'b1;
            vs_dly_q    <= 1'b1;
            blank_dly_q <= 1'b1;
            seen_hs_q   <= 1'b0;
            seen_vs_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            h_cnt_q     <= '0;
            a_cnt_q     <= '0;
            v_cnt_q     <= '0;
            al_cnt_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            oX          <= '0;
            oY          <= '0;
            oPIX_VALID  <= 1'b0;
            oH_TOTAL    <= '0;
            oV_TOTAL    <= '0;
            oFRAME_CNT  <= '0;
            oERR        <= '0;
            oLOCKED     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_dly_q    <= iHS;
            vs_dly_q    <= iVS;
            blank_dly_q <= iBLANK_n;
            seen_hs_q   <= seen_hs_q | hs_fall;
            seen_vs_q   <= seen_vs_q | vs_fall;
            frame_bad_q <= frame_bad_d;
            h_cnt_q     <= h_cnt_d;
            a_cnt_q     <= a_cnt_d;
            v_cnt_q     <= v_cnt_d;
            al_cnt_q    <= al_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            oX          <= x_cur;
            oY          <= y_cur;
            oPIX_VALID  <= iBLANK_n;
            oERR        <= err_d;
            oLOCKED     <= (state_d == LOCKED);
            if (h_chk) begin
                oH_TOTAL <= h_cnt_q;
            end
            if (v_chk) begin
                oV_TOTAL   <= v_cnt_q;
                oFRAME_CNT <= oFRAME_CNT + 8'd1;
            end
        end
    end

`ifdef VGA_MON_SUM_EN
    logic [15:0] sum_q, sum_d, sum_out_q, pix_term;

    // Restarting on every VS fall keeps the partial frame after reset out of the first sum.
    always_comb begin
        pix_term = iBLANK_n ? {8'd0, iPIX} : 16'd0;
        sum_d    = vs_fall ? pix_term : sum_q + pix_term;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sum_q     <= '0;
            sum_out_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (v_chk) begin
                sum_out_q <= sum_q;
            end
        end
    end

    assign oFRAME_SUM = sum_out_q;
`else
    logic unused_pix;
    assign unused_pix = ^iPIX;
    assign oFRAME_SUM = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a reduced 80x40 raster (64x32 active).
module tb_vga_timing_monitor;

    localparam int HT = 80, HA = 64, VT = 40, VA = 32;
    localparam int HS0 = 68, HS1 = 76, VSL = 34;
`ifdef VGA_MON_SUM_EN
    localparam int SUM_EXP = 16'hF800;
`else
    localparam int SUM_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, hs, vs, blank, clr;
    logic [7:0]  pix;
    logic [9:0]  oX, oY, oV_TOTAL;
    logic        oPIX_VALID, oLOCKED;
    logic [10:0] oH_TOTAL;
    logic [7:0]  oFRAME_CNT;
    logic [15:0] oFRAME_SUM;
    logic [3:0]  oERR;

    always #5 clk = ~clk;

    vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iHS(hs), .iVS(vs), .iBLANK_n(blank),
        .iPIX(pix), .iERR_CLR(clr), .oX(oX), .oY(oY), .oPIX_VALID(oPIX_VALID),
        .oH_TOTAL(oH_TOTAL), .oV_TOTAL(oV_TOTAL), .oFRAME_CNT(oFRAME_CNT),
        .oFRAME_SUM(oFRAME_SUM), .oERR(oERR), .oLOCKED(oLOCKED)
    );

    typedef enum {S_X, S_Y, S_PV, S_HT, S_VT, S_FC, S_ERR, S_LK, S_SUM} sel_t;
    typedef struct {
        int    pos;
        sel_t  sel;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0, n_bad = 0;
    int   fr_g = 0, vc_g = 0, hc_g = 0, cyc_g = 0;
    int   ltot_g = HT, lact_g = HA;
    bit   clr_g = 1'b0;

    function automatic int rd(sel_t s);
        case (s)
            S_X:     return int'(oX);
            S_Y:     return int'(oY);
            S_PV:    return int'(oPIX_VALID);
            S_HT:    return int'(oH_TOTAL);
            S_VT:    return int'(oV_TOTAL);
            S_FC:    return int'(oFRAME_CNT);
            S_ERR:   return int'(oERR);
            S_LK:    return int'(oLOCKED);
            default: return int'(oFRAME_SUM);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"},    rd(S_X),   0);
        chk({tag, "_y"},    rd(S_Y),   0);
        chk({tag, "_pv"},   rd(S_PV),  0);
        chk({tag, "_htot"}, rd(S_HT),  0);
        chk({tag, "_vtot"}, rd(S_VT),  0);
        chk({tag, "_fcnt"}, rd(S_FC),  0);
        chk({tag, "_err"},  rd(S_ERR), 0);
        chk({tag, "_lock"}, rd(S_LK),  0);
        chk({tag, "_sum"},  rd(S_SUM), 0);
    endtask

    // Present one raster pixel, then wait until the edge after it has been clocked.
    task automatic drive_next();
        hs    = !(hc_g >= HS0 && hc_g < HS1);
        vs    = !((vc_g == VSL && hc_g >= HS0) || vc_g == VSL + 1 || (vc_g == VSL + 2 && hc_g < HS0));
        blank = (hc_g < lact_g) && (vc_g < VA);
        pix   = 8'hFF;
        clr   = clr_g;
        @(negedge clk);
        clr_g = 1'b0;
        clr   = 1'b0;
        cyc_g++;
        hc_g++;
        if (hc_g >= ltot_g) begin
            hc_g   = 0;
            ltot_g = HT;
            lact_g = HA;
            vc_g++;
            if (vc_g == VT) begin
                vc_g = 0;
                fr_g++;
            end
        end
    endtask

    task automatic advance_through(input int f, input int v, input int h);
        bit hit;
        int guard;
        guard = 0;
        do begin
            hit = (fr_g == f && vc_g == v && hc_g == h);
            drive_next();
            guard++;
        end while (!hit && guard < 20000);
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL advance_timeout: got frame %0d line %0d, required frame %0d line %0d", fr_g, vc_g, f, v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; clr = 1'b0; pix = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // pos = frame*3200 + line*80 + col of the pixel just clocked
        vecs.push_back('{0,     S_PV,  1,       "first_pix_valid"});
        vecs.push_back('{0,     S_X,   0,       "first_pix_x"});
        vecs.push_back('{63,    S_X,   63,      "f0_last_x"});
        vecs.push_back('{64,    S_PV,  0,       "f0_blank_pv"});
        vecs.push_back('{147,   S_HT,  0,       "htot_before_qual"});
        vecs.push_back('{148,   S_HT,  80,      "htot_first_qual"});
        vecs.push_back('{2788,  S_VT,  0,       "vtot_unqual_vs"});
        vecs.push_back('{2788,  S_FC,  0,       "fcnt_unqual_vs"});
        vecs.push_back('{3200,  S_X,   0,       "f1_first_x"});
        vecs.push_back('{3200,  S_Y,   0,       "f1_first_y"});
        vecs.push_back('{3200,  S_PV,  1,       "f1_first_pv"});
        vecs.push_back('{3610,  S_X,   10,      "mid_x"});
        vecs.push_back('{3610,  S_Y,   5,       "mid_y"});
        vecs.push_back('{5743,  S_X,   63,      "last_x"});
        vecs.push_back('{5743,  S_Y,   31,      "last_y"});
        vecs.push_back('{5744,  S_PV,  0,       "after_last_pv"});
        vecs.push_back('{5987,  S_FC,  0,       "fcnt_before_f1"});
        vecs.push_back('{5987,  S_SUM, 0,       "sum_before_f1"});
        vecs.push_back('{5988,  S_VT,  40,      "vtot_f1"});
        vecs.push_back('{5988,  S_FC,  1,       "fcnt_f1"});
        vecs.push_back('{5988,  S_LK,  0,       "lock_good1"});
        vecs.push_back('{5988,  S_ERR, 0,       "err_f1"});
        vecs.push_back('{9187,  S_LK,  0,       "lock_before_f2"});
        vecs.push_back('{9188,  S_LK,  1,       "lock_rise_f2"});
        vecs.push_back('{9188,  S_SUM, SUM_EXP, "sum_f2"});
        vecs.push_back('{12388, S_FC,  3,       "fcnt_f3"});
        vecs.push_back('{12388, S_HT,  80,      "htot_f3"});
        vecs.push_back('{12388, S_ERR, 0,       "err_f3"});
        vecs.push_back('{12388, S_LK,  1,       "lock_f3"});

        foreach (vecs[i]) begin
            while (cyc_g <= vecs[i].pos) drive_next();
            chk(vecs[i].name, rd(vecs[i].sel), vecs[i].exp);
        end

        // One 81-clock line inside a locked frame.
        advance_through(4, 1, 79);
        ltot_g = HT + 1;
        advance_through(4, 3, 67);
        chk("long_pre_lock", rd(S_LK), 1);
        chk("long_pre_err",  rd(S_ERR), 0);
        advance_through(4, 3, 68);
        chk("long_err",  rd(S_ERR), 1);
        chk("long_lock", rd(S_LK), 0);
        chk("long_htot", rd(S_HT), 81);
        advance_through(4, 4, 68);
        chk("long_next_htot", rd(S_HT), 80);
        advance_through(4, 34, 68);
        chk("bad_frame_lock", rd(S_LK), 0);
        chk("bad_frame_fcnt", rd(S_FC), 4);
        advance_through(5, 34, 68);
        chk("relock_good1", rd(S_LK), 0);
        advance_through(6, 34, 68);
        chk("relock_locked", rd(S_LK), 1);
        chk("err_sticky", rd(S_ERR), 1);
        clr_g = 1'b1;
        drive_next();
        chk("err_cleared", rd(S_ERR), 0);

        // 63-pixel line with the clear pulse on the same cycle.
        advance_through(7, 4, 79);
        lact_g = HA - 1;
        advance_through(7, 5, 67);
        clr_g = 1'b1;
        advance_through(7, 5, 68);
        chk("clr_vs_set_err", rd(S_ERR), 2);
        chk("clr_vs_set_lock", rd(S_LK), 0);

        // Asynchronous reset in the middle of an active line.
        advance_through(7, 10, 30);
        rst_n = 1'b0;
        #2;
        chk_all_zero("midreset");
        repeat (3) drive_next();
        rst_n = 1'b1;
        advance_through(7, 10, 68);
        chk("post_rst_htot_unqual", rd(S_HT), 0);
        chk("post_rst_err0", rd(S_ERR), 0);
        advance_through(7, 11, 68);
        chk("post_rst_htot", rd(S_HT), 80);
        chk("post_rst_err1", rd(S_ERR), 0);
        advance_through(7, 34, 68);
        chk("post_rst_partial_fcnt", rd(S_FC), 0);
        chk("post_rst_partial_vtot", rd(S_VT), 0);
        chk("post_rst_partial_err",  rd(S_ERR), 0);
        advance_through(8, 34, 68);
        chk("post_rst_full_fcnt", rd(S_FC), 1);
        chk("post_rst_full_vtot", rd(S_VT), 40);
        chk("post_rst_full_err",  rd(S_ERR), 0);
        chk("post_rst_full_lock", rd(S_LK), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Passive receiver for the VGA raster interface driven by the display controller: it consumes the registered HS/VS/BLANK_n strobes and pixel index, reconstructs per-pixel X/Y coordinates, and measures line and frame geometry. It checks the geometry against the nominal 640x480 timing, reports sticky errors and a lock indication, and sits beside the controller outputs as the sink used for self-check and debug taps.

## Interface
- H_TOTAL, 800, expected clocks per line (HS fall to HS fall)
- V_TOTAL, 525, expected lines per frame (VS fall to VS fall)
- H_ACTIVE, 640, expected BLANK_n-high clocks per active line
- V_ACTIVE, 480, expected active lines per frame
- iVGA_CLK  in  1  pixel clock; the only clock
- iRST_n  in  1  asynchronous active-low reset
- iHS / iVS  in  1 each  active-low syncs, same clock domain
- iBLANK_n  in  1  high = active pixel
- iPIX  in  8  colour index accompanying the active pixel
- iERR_CLR  in  1  one-cycle pulse; clears oERR
- oX / oY  out  10 each  coordinate of the pixel flagged by oPIX_VALID
- oPIX_VALID  out  1  registered copy of iBLANK_n
- oH_TOTAL  out  11  last measured line period in clocks
- oV_TOTAL  out  10  last measured frame length in lines
- oFRAME_CNT  out  8  completed-frame count
- oFRAME_SUM  out  16  per-frame pixel checksum (see Configuration)
- oERR  out  4  sticky flags {v_active, v_total, h_active, h_total}
- oLOCKED  out  1  geometry matches for two consecutive frames

## Operation
- Edge detect: hs_fall = hs_d & ~iHS, vs_fall = vs_d & ~iVS, blank_fall = blank_d & ~iBLANK_n; hs_d/vs_d/blank_d reset to 1.
- Line period: on hs_fall, oH_TOTAL <= h_cnt and h_cnt <= 1; otherwise h_cnt increments, saturating at 2047.
- Active width: a_cnt counts iBLANK_n-high clocks, cleared on hs_fall. On hs_fall with a_cnt != 0, the line is an active line and a_cnt is compared with H_ACTIVE.
- Frame length: v_cnt counts hs_falls. On vs_fall, oV_TOTAL <= v_cnt, then v_cnt <= (hs_fall ? 1 : 0); an HS fall coincident with VS fall belongs to the new frame. Active-line count is compared with V_ACTIVE on vs_fall, then cleared.
- Coordinates: x counts active clocks and is cleared on hs_fall. y increments on blank_fall and is cleared on vs_fall. Both saturate at 1023.
- Qualification: flags seen_hs and seen_vs, both cleared by reset. No measurement, compare, oH_TOTAL or oV_TOTAL update occurs until the first edge of that kind has been seen; the first partial line and frame after reset are never checked.
- Errors: a mismatch sets its oERR bit. iERR_CLR clears all bits. If a set and a clear land on the same cycle, the set wins.
- Lock FSM states:
  - UNLOCKED -> GOOD1 on a vs_fall closing a frame with no mismatch.
  - GOOD1 -> LOCKED on the next clean vs_fall.
  - Any state -> UNLOCKED on the cycle of any mismatch, including mid-frame h mismatches.
  - oLOCKED = (state == LOCKED).
- oFRAME_CNT increments on each qualified vs_fall and wraps 255 -> 0.

## Timing
- All outputs are registered. Reset value of every output is 0, and the lock FSM resets to UNLOCKED.
- oX, oY, oPIX_VALID lag the input pixel by exactly 1 clock.
- oH_TOTAL, oV_TOTAL, oERR, oLOCKED, oFRAME_CNT and oFRAME_SUM update 1 clock after the edge-detect cycle that closes the line or frame.
- An asynchronous reset mid-frame returns all state immediately. Qualification restarts, so there are no spurious errors.

## Configuration
- VGA_MON_SUM_EN defined: a 16-bit accumulator adds iPIX on every active clock, wrapping mod 65536. On a qualified vs_fall it is latched to oFRAME_SUM and cleared.
- VGA_MON_SUM_EN undefined: no accumulator, iPIX is ignored, and oFRAME_SUM is tied to 0.

## Test plan
- Nominal 640x480 timing, 4 frames -> oH_TOTAL=800, oV_TOTAL=525, oERR=0, oLOCKED rises 1 clock after the vs_fall ending the second qualified frame.
- One 801-clock line in a locked frame -> oERR[0]=1 and oLOCKED=0 one clock after that hs_fall. oLOCKED reasserts after two clean frames, and oERR[0] stays set until iERR_CLR.
- Pixel coordinates -> first active pixel gives oX=0, oY=0 with oPIX_VALID one clock later; last active pixel gives oX=639, oY=479.
- Reset asserted mid-line -> all outputs 0. The following partial line and frame produce oERR=0 and oFRAME_CNT=0 until the first full frame closes.
- iERR_CLR on the same clock as an h_active mismatch (639-pixel line) -> oERR[1]=1 afterwards.
- With VGA_MON_SUM_EN, constant iPIX=8'h01 -> oFRAME_SUM=16'hB000 (307200 mod 65536). Without the macro -> oFRAME_SUM=0.
